adc_reader: RTL and testbench

- Controller for an 8-bit parallel ADC (CONVST/BUSY/CS/RD style); the read-side counterpart of the board's parallel DAC writer.
- Periodically starts a conversion, waits for the converter's BUSY handshake and strobes the data bus.
- Presents the latched sample on data_out with a one-cycle data_valid pulse, and mirrors it on led_out.
- Sits between the board ADC pins and user logic, for example a loopback check against the DAC path.

---
 rtl/adc_reader_if.sv | 25 ++
 rtl/adc_reader.sv | 177 +++++++++++++++++
 tb/tb_adc_reader.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_reader_if.sv
// Pin bundle for the 8-bit parallel ADC (CONVST/BUSY/CS/RD style).
// The controller takes the master side, the converter (or its model) the slave side.
interface adc_reader_if;
    logic       adc_convstn;
    logic       adc_csn;
    logic       adc_rdn;
    logic       adc_busy;
    logic [7:0] adc_d;

    modport master (
        output adc_convstn,
        output adc_csn,
        output adc_rdn,
        input  adc_busy,
        input  adc_d
    );

    modport slave (
        input  adc_convstn,
        input  adc_csn,
        input  adc_rdn,
        output adc_busy,
        output adc_d
    );
endinterface

// File: rtl/adc_reader.sv
// Parallel ADC read controller.
// A free-running sample timer requests conversions. Each conversion pulses
// CONVST, waits for BUSY to rise and then fall, and strobes CS/RD to read the
// data bus. Every strobe and result output comes straight from a flop.
module adc_reader #(
    parameter int SAMPLE_PERIOD = 300,
    parameter int CONV_PULSE    = 20,
    parameter int RD_WIDTH      = 30,
    parameter int TIMEOUT       = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         err_clr,
    adc_reader_if.master adc,
    output logic [7:0]   data_out,
    output logic         data_valid,
    output logic [7:0]   led_out,
    output logic         timeout_err,
    output logic         overrun_err
);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_HI,
        WAIT_LO,
        READ
    } state_t;

    // Each "last cycle" constant is parameter-1, and the compares are >=,
    // so the shared counter can never wrap while it stays in one state.
    localparam logic [15:0] PERIOD_LAST  = 16'(SAMPLE_PERIOD - 1);
    localparam logic [15:0] CONV_LAST    = 16'(CONV_PULSE - 1);
    localparam logic [15:0] RD_LAST      = 16'(RD_WIDTH - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] period_cnt;
    logic [15:0] cycle_cnt;
    logic        busy_meta;
    logic        busy_s;
    logic        tick;
    logic        convstn_q;
    logic        csn_q;
    logic        rdn_q;

    assign adc.adc_convstn = convstn_q;
    assign adc.adc_csn     = csn_q;
    assign adc.adc_rdn     = rdn_q;

    // BUSY arrives from the converter's own timing domain; two flops before the FSM sees it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= adc.adc_busy;
            busy_s    <= busy_meta;
        end
    end

    // Sample timer: counts only while enabled and sits at zero otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= 16'd0;
        end else if (!en) begin
            period_cnt <= 16'd0;
        end else if (period_cnt >= PERIOD_LAST) begin
            period_cnt <= 16'd0;
        end else begin
            period_cnt <= period_cnt + 16'd1;
        end
    end

    assign tick = en && (period_cnt == PERIOD_LAST);

    // Conversion sequencer together with the sticky error flags and the result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cycle_cnt   <= 16'd0;
            convstn_q   <= 1'b1;
            csn_q       <= 1'b1;
            rdn_q       <= 1'b1;
            data_out    <= 8'h00;
            led_out     <= 8'h00;
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            // The clear comes first so that an error raised in the same cycle overrides it
            if (err_clr) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end

            // A tick that finds the sequencer busy is counted as an overrun and dropped
            if (tick && (state != IDLE)) begin
                overrun_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state     <= CONV;
                        cycle_cnt <= 16'd0;
                        convstn_q <= 1'b0;
                    end
                end

                CONV: begin
                    if (cycle_cnt >= CONV_LAST) begin
                        state     <= WAIT_HI;
                        cycle_cnt <= 16'd0;
                        convstn_q <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + 16'd1;
                    end
                end

                WAIT_HI: begin
                    if (busy_s) begin
                        state     <= WAIT_LO;
                        cycle_cnt <= 16'd0;
                    end else if (cycle_cnt >= TIMEOUT_LAST) begin
                        state       <= IDLE;
                        cycle_cnt   <= 16'd0;
                        timeout_err <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + 16'd1;
                    end
                end

                WAIT_LO: begin
                    if (!busy_s) begin
                        state     <= READ;
                        cycle_cnt <= 16'd0;
                        csn_q     <= 1'b0;
                        rdn_q     <= 1'b0;
                    end else if (cycle_cnt >= TIMEOUT_LAST) begin
                        state       <= IDLE;
                        cycle_cnt   <= 16'd0;
                        timeout_err <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + 16'd1;
                    end
                end

                READ: begin
                    if (cycle_cnt >= RD_LAST) begin
                        state      <= IDLE;
                        cycle_cnt  <= 16'd0;
                        csn_q      <= 1'b1;
                        rdn_q      <= 1'b1;
                        data_out   <= adc.adc_d;
                        led_out    <= adc.adc_d;
                        data_valid <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + 16'd1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cycle_cnt <= 16'd0;
                    convstn_q <= 1'b1;
                    csn_q     <= 1'b1;
                    rdn_q     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_reader.sv
// Self-checking bench for adc_reader.
// A behavioural ADC model answers every CONVST pulse and queues the value it
// will present; a monitor pops that queue on each data_valid pulse. Other
// monitors measure the strobe widths and record when conversions start.
module tb_adc_reader;

    localparam int SAMPLE_PERIOD = 300;
    localparam int CONV_PULSE    = 20;
    localparam int RD_WIDTH      = 30;
    localparam int TIMEOUT       = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic [7:0] led_out;
    logic       timeout_err;
    logic       overrun_err;

    adc_reader_if bus ();

    adc_reader #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .CONV_PULSE   (CONV_PULSE),
        .RD_WIDTH     (RD_WIDTH),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .err_clr    (err_clr),
        .adc        (bus),
        .data_out   (data_out),
        .data_valid (data_valid),
        .led_out    (led_out),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] adc_values[$];
    logic [7:0] last_expected = 8'h00;

    int busy_delay = 5;
    int busy_len = 100;
    bit busy_enable = 1'b1;
    bit rand_mode = 1'b0;

    int  dv_count = 0;
    bit  prev_dv = 1'b0;
    int  fall_count = 0;
    int  last_fall = 0;
    int  prev_fall = 0;
    int  conv_len = 0;
    int  csn_len = 0;
    int  rdn_len = 0;
    bit  csn_low_seen = 1'b0;

    always #5 clk = ~clk;

    // Cycle counter used to timestamp events seen on the falling edge
    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    endtask

    // Behavioural converter: every CONVST fall produces one sample with a BUSY pulse
    initial begin
        logic [7:0] v;
        bus.adc_busy = 1'b0;
        bus.adc_d    = 8'h00;
        forever begin
            @(negedge bus.adc_convstn);
            if (rst && busy_enable) begin
                if (rand_mode) begin
                    busy_delay = $urandom_range(1, 10);
                    busy_len   = $urandom_range(30, 150);
                end
                if (adc_values.size() != 0) v = adc_values.pop_front();
                else v = 8'($urandom);
                exp_q.push_back(v);
                last_expected = v;
                repeat (busy_delay) @(negedge clk);
                bus.adc_busy = 1'b1;
                bus.adc_d    = v;
                repeat (busy_len) @(negedge clk);
                bus.adc_busy = 1'b0;
            end
        end
    end

    // Scoreboard: each data_valid pulse must match the oldest outstanding sample
    always @(negedge clk) begin
        if (rst) begin
            if (prev_dv) check_output("dv_single_pulse", data_valid, 1'b0);
            if (data_valid) begin
                dv_count++;
                if (exp_q.size() == 0) begin
                    check_output("sb_unexpected_valid", exp_q.size(), 1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check_output("sb_data_out", data_out, e);
                    check_output("sb_led_out", led_out, e);
                end
            end
            prev_dv = data_valid;
        end else begin
            prev_dv = 1'b0;
        end
    end

    // Strobe monitor: pulse widths, read strobe pairing and conversion start times
    always @(negedge clk) begin
        if (!rst) begin
            conv_len = 0;
            csn_len  = 0;
            rdn_len  = 0;
        end else begin
            if (!bus.adc_convstn) begin
                if (conv_len == 0) begin
                    fall_count++;
                    prev_fall = last_fall;
                    last_fall = cyc;
                end
                conv_len++;
            end else if (conv_len != 0) begin
                check_output("convst_width", conv_len, CONV_PULSE);
                conv_len = 0;
            end
            if (!bus.adc_csn) begin
                csn_low_seen = 1'b1;
                csn_len++;
            end else if (csn_len != 0) begin
                check_output("csn_width", csn_len, RD_WIDTH);
                csn_len = 0;
            end
            if (!bus.adc_rdn) begin
                rdn_len++;
            end else if (rdn_len != 0) begin
                check_output("rdn_width", rdn_len, RD_WIDTH);
                rdn_len = 0;
            end
        end
    end

    task automatic wait_valids(input int n, input int budget, input string name);
        int start = dv_count;
        for (int i = 0; i < budget && dv_count < start + n; i++) @(negedge clk);
        check_output(name, dv_count - start, n);
    endtask

    task automatic wait_fall(input int budget, input string name);
        int start = fall_count;
        for (int i = 0; i < budget && fall_count <= start; i++) @(negedge clk);
        check_output(name, fall_count > start, 1'b1);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic apply_stimulus();
        int t0;
        int fc;

        // Asynchronous reset with no clock edge involved
        #2 rst = 1'b0;
        #1;
        check_output("rst_convstn", bus.adc_convstn, 1'b1);
        check_output("rst_csn", bus.adc_csn, 1'b1);
        check_output("rst_rdn", bus.adc_rdn, 1'b1);
        check_output("rst_data_out", data_out, 8'h00);
        check_output("rst_led_out", led_out, 8'h00);
        check_output("rst_flags", {data_valid, timeout_err, overrun_err}, 3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Nominal cycle followed by a second conversion to check the period
        adc_values.push_back(8'hA5);
        adc_values.push_back(8'hA5);
        en = 1'b1;
        wait_valids(1, 600, "nominal_valid");
        check_output("nominal_data_out", data_out, 8'hA5);
        check_output("nominal_led_out", led_out, 8'hA5);
        wait_fall(400, "nominal_second_start");
        check_output("nominal_period", last_fall - prev_fall, SAMPLE_PERIOD);
        wait_valids(1, 500, "nominal_second_valid");

        // Data sweep through extreme and alternating patterns
        adc_values.push_back(8'h00);
        adc_values.push_back(8'hFF);
        adc_values.push_back(8'h5A);
        wait_valids(3, 1600, "sweep_valids");
        check_output("sweep_no_errors", {timeout_err, overrun_err}, 2'b00);

        // Random data and random BUSY timing
        rand_mode = 1'b1;
        wait_valids(5, 2600, "random_valids");
        rand_mode  = 1'b0;
        busy_delay = 5;
        busy_len   = 100;
        check_output("random_no_errors", {timeout_err, overrun_err}, 2'b00);

        // BUSY never rises: the handshake times out and nothing is read
        busy_enable  = 1'b0;
        csn_low_seen = 1'b0;
        wait_fall(400, "timeout_start");
        t0 = last_fall;
        for (int i = 0; i < 1100 && !timeout_err; i++) @(negedge clk);
        check_output("timeout_latency", cyc - t0, CONV_PULSE + TIMEOUT);
        check_output("timeout_no_read", csn_low_seen, 1'b0);
        check_output("timeout_data_hold", data_out, last_expected);
        busy_enable = 1'b1;
        wait_valids(1, 1000, "timeout_resume_valid");
        check_output("timeout_sticky", timeout_err, 1'b1);
        pulse_err_clr();
        check_output("timeout_cleared", {timeout_err, overrun_err}, 2'b00);

        // Overrun: a long BUSY makes every other tick land mid-conversion
        busy_len = 280;
        for (int i = 0; i < 800 && !overrun_err; i++) @(negedge clk);
        check_output("overrun_set", overrun_err, 1'b1);
        wait_fall(700, "overrun_next_start");
        check_output("overrun_period", last_fall - prev_fall, 2 * SAMPLE_PERIOD);
        wait_valids(1, 700, "overrun_valid");
        pulse_err_clr();
        check_output("overrun_cleared", overrun_err, 1'b0);
        for (int i = 0; i < 700 && !overrun_err; i++) @(negedge clk);
        check_output("overrun_set_again", overrun_err, 1'b1);
        busy_len = 100;
        wait_valids(2, 1400, "overrun_recover_valids");
        pulse_err_clr();
        check_output("overrun_recover_clear", {timeout_err, overrun_err}, 2'b00);

        // Reset asserted while the read strobes are low
        for (int i = 0; i < 600 && bus.adc_csn; i++) @(negedge clk);
        check_output("midrst_in_read", bus.adc_csn, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("midrst_strobes", {bus.adc_convstn, bus.adc_csn, bus.adc_rdn}, 3'b111);
        check_output("midrst_data_out", data_out, 8'h00);
        check_output("midrst_led_out", led_out, 8'h00);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;

        // Dropping en while waiting for BUSY to fall lets that sample finish
        wait_fall(400, "disable_start");
        for (int i = 0; i < 60 && !bus.adc_busy; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        en = 1'b0;
        wait_valids(1, 300, "disable_valid");
        fc = fall_count;
        repeat (700) @(negedge clk);
        check_output("disable_no_new_start", fall_count, fc);
        check_output("sb_drained", exp_q.size(), 0);
    endtask

    // Main sequence
    initial begin
        apply_stimulus();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global time limit in case the sequence stalls
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("[TB] %0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
